// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word reads under a
// credit limit of DEPTH, and buffers PC-tagged words for the decode stage.
// Optional build macro FETCH_PERF_EN adds the fetch_count delivered-word counter.
module fetch_unit #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned      DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_resp_valid,
  input  logic [WIDTH-1:0] imem_resp_data,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr_data,
  output logic [WIDTH-1:0] instr_pc,
  input  logic             instr_ready,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      fetch_count
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] pc;
  } entry_t;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             started_q;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W-1:0] twr_q, twr_d, trd_q, trd_d;
  entry_t           fifo_q [DEPTH];
  logic [WIDTH-1:0] tag_q  [DEPTH];

  logic credit_ok;
  logic req_acc;
  logic resp_fire;
  logic push;
  logic pop;
  logic redirect_lsb_unused;

  // Handshake decode; requests are held off in the redirect cycle
  always_comb begin
    credit_ok      = (SUM_W'(out_q) + SUM_W'(cnt_q)) < SUM_W'(DEPTH);
    imem_req_valid = started_q && credit_ok && !redirect_valid;
    req_acc        = imem_req_valid && imem_req_ready;
    resp_fire      = imem_resp_valid && (out_q != '0);
    push           = resp_fire && (drop_q == '0) && !redirect_valid;
    pop            = instr_valid && instr_ready;
  end

  assign imem_req_addr       = pc_q;
  assign instr_valid         = (cnt_q != '0);
  assign instr_data          = fifo_q[rd_q].data;
  assign instr_pc            = fifo_q[rd_q].pc;
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  // Next-state for PC, credit counters and queue pointers; redirect overrides
  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q;
    drop_d = drop_q;
    cnt_d  = cnt_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    twr_d  = twr_q;
    trd_d  = trd_q;
    if (req_acc) begin
      pc_d  = pc_q + WIDTH'(4);
      out_d = out_d + CNT_W'(1);
      twr_d = twr_q + PTR_W'(1);
    end
    if (resp_fire) begin
      out_d = out_d - CNT_W'(1);
      trd_d = trd_q + PTR_W'(1);
      if (drop_q != '0) drop_d = drop_q - CNT_W'(1);
    end
    if (push) begin
      cnt_d = cnt_d + CNT_W'(1);
      wr_d  = wr_q + PTR_W'(1);
    end
    if (pop) begin
      cnt_d = cnt_d - CNT_W'(1);
      rd_d  = rd_q + PTR_W'(1);
    end
    if (redirect_valid) begin
      pc_d   = {redirect_pc[WIDTH-1:2], 2'b00};
      drop_d = out_d;
      cnt_d  = '0;
      wr_d   = '0;
      rd_d   = '0;
    end
  end

  // State registers, instruction FIFO storage and in-flight PC tag queue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      started_q <= 1'b0;
      out_q     <= '0;
      drop_q    <= '0;
      cnt_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      twr_q     <= '0;
      trd_q     <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      pc_q      <= pc_d;
      started_q <= 1'b1;
      out_q     <= out_d;
      drop_q    <= drop_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      twr_q     <= twr_d;
      trd_q     <= trd_d;
      if (push)    fifo_q[wr_q] <= entry_t'{data: imem_resp_data, pc: tag_q[trd_q]};
      if (req_acc) tag_q[twr_q] <= pc_q;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_q;

  // Count words actually handed to the consumer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     perf_q <= '0;
    else if (pop) perf_q <= perf_q + 32'd1;
  end

  assign fetch_count = perf_q;
`endif

`ifndef SYNTHESIS
  // A response with nothing outstanding means the memory broke ordering
  resp_without_req_a: assert property (@(posedge clk) disable iff (!rst)
    imem_resp_valid |-> (out_q != '0));
`endif

endmodule
